// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I scpu datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the PC, IR, register-file and memory strobes.
module mc_ctrl_fsm #(
    parameter int CNT_W      = 32,
    parameter bit RESET_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             halt,
    output logic [1:0]       trap_cause,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam state_t RST_STATE = RESET_IDLE ? IDLE : FETCH;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_OPIMM  = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;

    // Opcodes the datapath can execute (SYSTEM is recognised but traps).
    function automatic logic is_exec_op(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_FENCE, OP_OPIMM, OP_AUIPC, OP_STORE,
            OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [1:0]       trap_cause_r;
    logic [1:0]       trap_cause_nxt_s;
    logic [CNT_W-1:0] instret_r;

    logic [6:0]       opcode_s;
    logic [4:0]       rd_s;
    logic             unused_inst_s;

    logic             imem_req_s;
    logic             ir_write_s;
    logic             pc_write_s;
    logic [1:0]       pc_src_s;
    logic             dmem_req_s;
    logic             dmem_we_s;
    logic             reg_write_s;
    logic [1:0]       wb_sel_s;
    logic             alu_src_a_s;
    logic             alu_src_b_s;
    logic             halt_s;
    logic             retire_s;

    assign opcode_s      = inst[6:0];
    assign rd_s          = inst[11:7];
    assign unused_inst_s = ^inst[31:12];

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Trap cause is captured on the DECODE->TRAP transition and held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_cause_r <= CAUSE_NONE;
        end else begin
            trap_cause_r <= trap_cause_nxt_s;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        next_state_s     = state_r;
        trap_cause_nxt_s = trap_cause_r;
        imem_req_s       = 1'b0;
        ir_write_s       = 1'b0;
        pc_write_s       = 1'b0;
        pc_src_s         = 2'd0;
        dmem_req_s       = 1'b0;
        dmem_we_s        = 1'b0;
        reg_write_s      = 1'b0;
        wb_sel_s         = 2'd0;
        alu_src_a_s      = 1'b0;
        alu_src_b_s      = 1'b0;
        halt_s           = 1'b0;
        retire_s         = 1'b0;

        case (state_r)
            IDLE: begin
                next_state_s = FETCH;
            end

            FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready) begin
                    ir_write_s   = 1'b1;
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end

            DECODE: begin
                if (opcode_s == OP_SYSTEM) begin
                    trap_cause_nxt_s = CAUSE_SYSTEM;
                    next_state_s     = TRAP;
                end else if (!is_exec_op(opcode_s)) begin
                    trap_cause_nxt_s = CAUSE_ILLEGAL;
                    next_state_s     = TRAP;
                end else begin
                    next_state_s = EXEC;
                end
            end

            EXEC: begin
                case (opcode_s)
                    OP_BRANCH: begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = branch_taken ? 2'd1 : 2'd0;
                        retire_s     = 1'b1;
                        next_state_s = FETCH;
                    end
                    OP_FENCE: begin
                        pc_write_s   = 1'b1;
                        retire_s     = 1'b1;
                        next_state_s = FETCH;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_s  = 1'b1;
                        next_state_s = MEM;
                    end
                    OP_OP: begin
                        next_state_s = WB;
                    end
                    OP_OPIMM, OP_LUI, OP_JAL, OP_JALR: begin
                        alu_src_b_s  = 1'b1;
                        next_state_s = WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a_s  = 1'b1;
                        alu_src_b_s  = 1'b1;
                        next_state_s = WB;
                    end
                    default: begin
                        // Unreachable after DECODE filtering; stop rather than run garbage.
                        next_state_s = TRAP;
                    end
                endcase
            end

            MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (opcode_s == OP_STORE);
                if (dmem_ready) begin
                    if (opcode_s == OP_STORE) begin
                        pc_write_s   = 1'b1;
                        retire_s     = 1'b1;
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = WB;
                    end
                end else begin
                    next_state_s = MEM;
                end
            end

            WB: begin
                reg_write_s = (rd_s != 5'd0);
                pc_write_s  = 1'b1;
                retire_s    = 1'b1;
                case (opcode_s)
                    OP_LOAD: begin
                        wb_sel_s = 2'd1;
                        pc_src_s = 2'd0;
                    end
                    OP_JAL: begin
                        wb_sel_s = 2'd2;
                        pc_src_s = 2'd1;
                    end
                    OP_JALR: begin
                        wb_sel_s = 2'd2;
                        pc_src_s = 2'd2;
                    end
                    default: begin
                        wb_sel_s = 2'd0;
                        pc_src_s = 2'd0;
                    end
                endcase
                next_state_s = FETCH;
            end

            TRAP: begin
                halt_s       = 1'b1;
                next_state_s = TRAP;
            end

            default: begin
                next_state_s = TRAP;
            end
        endcase
    end

    assign imem_req   = imem_req_s;
    assign ir_write   = ir_write_s;
    assign pc_write   = pc_write_s;
    assign pc_src     = pc_src_s;
    assign dmem_req   = dmem_req_s;
    assign dmem_we    = dmem_we_s;
    assign reg_write  = reg_write_s;
    assign wb_sel     = wb_sel_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign halt       = halt_s;
    assign retire     = retire_s;
    assign trap_cause = trap_cause_r;
    assign instret    = instret_r;
    assign state_dbg  = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-cycle expected output words are queued as
// stimulus is driven and popped/compared at the following falling edge.
module tb_mc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req, ir_write, pc_write, dmem_req, dmem_we, reg_write;
    logic        alu_src_a, alu_src_b, halt, retire;
    logic [1:0]  pc_src, wb_sel, trap_cause;
    logic [31:0] instret;
    logic [2:0]  state_dbg;

    logic        rst2;
    logic [31:0] inst2;
    logic        imem_ready2;
    logic        branch_taken2;
    logic        dmem_ready2;
    logic        imem_req2, ir_write2, pc_write2, dmem_req2, dmem_we2, reg_write2;
    logic        alu_src_a2, alu_src_b2, halt2, retire2;
    logic [1:0]  pc_src2, wb_sel2, trap_cause2;
    logic [1:0]  instret2;
    logic [2:0]  state_dbg2;

    mc_ctrl_fsm #(.CNT_W(32), .RESET_IDLE(1'b1)) dut (
        .clk(clk), .rst(rst), .inst(inst), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .halt(halt), .trap_cause(trap_cause),
        .retire(retire), .instret(instret), .state_dbg(state_dbg)
    );

    // Narrow counter, reset straight into FETCH: exercises wrap and RESET_IDLE=0.
    mc_ctrl_fsm #(.CNT_W(2), .RESET_IDLE(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .inst(inst2), .branch_taken(branch_taken2),
        .imem_ready(imem_ready2), .dmem_ready(dmem_ready2),
        .imem_req(imem_req2), .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .reg_write(reg_write2), .wb_sel(wb_sel2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .halt(halt2), .trap_cause(trap_cause2),
        .retire(retire2), .instret(instret2), .state_dbg(state_dbg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: imem_req ir_write pc_write pc_src dmem_req dmem_we reg_write
    //              wb_sel alu_src_a alu_src_b halt trap_cause retire state
    logic [18:0] obs;
    assign obs = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write,
                  wb_sel, alu_src_a, alu_src_b, halt, trap_cause, retire, state_dbg};

    localparam logic [18:0] IREQ = 19'd1 << 18;
    localparam logic [18:0] IRW  = 19'd1 << 17;
    localparam logic [18:0] PCW  = 19'd1 << 16;
    localparam logic [18:0] PCS1 = 19'd1 << 14;
    localparam logic [18:0] PCS2 = 19'd2 << 14;
    localparam logic [18:0] DREQ = 19'd1 << 13;
    localparam logic [18:0] DWE  = 19'd1 << 12;
    localparam logic [18:0] RW   = 19'd1 << 11;
    localparam logic [18:0] WB1  = 19'd1 << 9;
    localparam logic [18:0] WB2  = 19'd2 << 9;
    localparam logic [18:0] ASA  = 19'd1 << 8;
    localparam logic [18:0] ASB  = 19'd1 << 7;
    localparam logic [18:0] HALT = 19'd1 << 6;
    localparam logic [18:0] TC1  = 19'd1 << 4;
    localparam logic [18:0] TC2  = 19'd2 << 4;
    localparam logic [18:0] RET  = 19'd1 << 3;
    localparam logic [18:0] S0   = 19'd0;
    localparam logic [18:0] S1   = 19'd1;
    localparam logic [18:0] S2   = 19'd2;
    localparam logic [18:0] S3   = 19'd3;
    localparam logic [18:0] S4   = 19'd4;
    localparam logic [18:0] S5   = 19'd5;
    localparam logic [18:0] S6   = 19'd6;

    typedef struct {
        string       tag;
        logic [18:0] outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt;
    int          total_cnt;
    logic [31:0] exp_cnt;
    logic [31:0] cur_inst;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
    task automatic step(input string tag, input logic ir, input logic dr, input logic bt,
                        input logic [18:0] e);
        exp_t r;
        inst         = cur_inst;
        imem_ready   = ir;
        dmem_ready   = dr;
        branch_taken = bt;
        sb.push_back('{tag, e, exp_cnt});
        @(negedge clk);
        r = sb.pop_front();
        check(r.tag, {13'd0, obs}, {13'd0, r.outs});
        check({r.tag, "_instret"}, instret, r.cnt);
        @(posedge clk);
        #1;
        if (e[3]) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic run_fde(input string tag, input logic [31:0] instr, input logic bt,
                           input logic [18:0] exec_e);
        cur_inst = instr;
        step({tag, "_fetch"},  1'b1, 1'b0, 1'b0, S1 | IREQ | IRW);
        step({tag, "_decode"}, 1'b0, 1'b0, 1'b0, S2);
        step({tag, "_exec"},   1'b0, 1'b0, bt,   exec_e);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_outs"}, {13'd0, obs}, 32'd0);
        check({tag, "_instret"}, instret, 32'd0);
        exp_cnt = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        exp_cnt       = 32'd0;
        cur_inst      = 32'd0;
        rst           = 1'b1;
        inst          = 32'd0;
        branch_taken  = 1'b0;
        imem_ready    = 1'b0;
        dmem_ready    = 1'b0;
        rst2          = 1'b1;
        inst2         = 32'h0000000F;
        imem_ready2   = 1'b1;
        branch_taken2 = 1'b0;
        dmem_ready2   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 1'b0, S0);

        // ADDI x1,x0,5
        run_fde("addi", 32'h00500093, 1'b0, S3 | ASB);
        step("addi_wb", 1'b0, 1'b0, 1'b0, S5 | RW | PCW | RET);

        // BEQ taken, with one fetch wait cycle and a stray dmem_ready in DECODE
        cur_inst = 32'h00000463;
        step("beq_t_fwait",  1'b0, 1'b0, 1'b0, S1 | IREQ);
        step("beq_t_fetch",  1'b1, 1'b0, 1'b0, S1 | IREQ | IRW);
        step("beq_t_decode", 1'b0, 1'b1, 1'b0, S2);
        step("beq_t_exec",   1'b0, 1'b0, 1'b1, S3 | PCW | PCS1 | RET);

        // BEQ not taken, stray imem_ready in EXEC
        cur_inst = 32'h00000463;
        step("beq_n_fetch",  1'b1, 1'b0, 1'b0, S1 | IREQ | IRW);
        step("beq_n_decode", 1'b0, 1'b0, 1'b0, S2);
        step("beq_n_exec",   1'b1, 1'b0, 1'b0, S3 | PCW | RET);

        // LW x2,0(x1) with three memory wait cycles
        run_fde("lw", 32'h0000a103, 1'b0, S3 | ASB);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", 1'b0, 1'b0, 1'b0, S4 | DREQ);
        step("lw_mem_rdy", 1'b0, 1'b1, 1'b0, S4 | DREQ);
        step("lw_wb",      1'b0, 1'b0, 1'b0, S5 | RW | WB1 | PCW | RET);

        // SW x2,0(x1) with zero-wait ready
        run_fde("sw", 32'h0020a023, 1'b0, S3 | ASB);
        step("sw_mem", 1'b0, 1'b1, 1'b0, S4 | DREQ | DWE | PCW | RET);

        // JALR x0,0(x1): rd=0 suppresses reg_write
        run_fde("jalr", 32'h00008067, 1'b0, S3 | ASB);
        step("jalr_wb", 1'b0, 1'b0, 1'b0, S5 | WB2 | PCW | PCS2 | RET);

        // JAL x1,8
        run_fde("jal", 32'h008000ef, 1'b0, S3 | ASB);
        step("jal_wb", 1'b0, 1'b0, 1'b0, S5 | RW | WB2 | PCW | PCS1 | RET);

        // AUIPC x2,0
        run_fde("auipc", 32'h00000117, 1'b0, S3 | ASA | ASB);
        step("auipc_wb", 1'b0, 1'b0, 1'b0, S5 | RW | PCW | RET);

        // ADD x3,x1,x2
        run_fde("add", 32'h002081b3, 1'b0, S3);
        step("add_wb", 1'b0, 1'b0, 1'b0, S5 | RW | PCW | RET);

        // FENCE
        run_fde("fence", 32'h0000000f, 1'b0, S3 | PCW | RET);

        // SW interrupted by reset while waiting in MEM
        run_fde("sw_rst", 32'h0020a023, 1'b0, S3 | ASB);
        step("sw_rst_mem", 1'b0, 1'b0, 1'b0, S4 | DREQ | DWE);
        do_reset("rst_in_mem");
        step("idle2", 1'b1, 1'b1, 1'b0, S0);

        // Illegal opcode: halts with cause 1 and ignores ready inputs
        cur_inst = 32'hFFFFFFFF;
        step("ill_fetch",  1'b1, 1'b0, 1'b0, S1 | IREQ | IRW);
        step("ill_decode", 1'b0, 1'b0, 1'b0, S2);
        for (int i = 0; i < 3; i++) step("ill_trap", 1'b1, 1'b1, 1'b1, S6 | HALT | TC1);

        // ECALL: halts with cause 2
        do_reset("rst_in_trap");
        step("idle3", 1'b0, 1'b0, 1'b0, S0);
        cur_inst = 32'h00000073;
        step("ecall_fetch",  1'b1, 1'b0, 1'b0, S1 | IREQ | IRW);
        step("ecall_decode", 1'b0, 1'b0, 1'b0, S2);
        for (int i = 0; i < 2; i++) step("ecall_trap", 1'b1, 1'b0, 1'b0, S6 | HALT | TC2);

        // Second instance: straight to FETCH, FENCE stream, 2-bit counter wraps
        rst2 = 1'b0;
        @(negedge clk);
        check("noidle_state", {29'd0, state_dbg2}, 32'd1);
        check("noidle_instret", {30'd0, instret2}, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check("wrap_pre", {30'd0, instret2}, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("wrap_post", {30'd0, instret2}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
